// File: rtl/alu_control_md.sv
// ALU-control decoder with a registered decode stage and an iterative signed
// multiply/divide engine that owns the HI/LO registers.
module alu_control_md #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [3:0]       ALUInput,
    output logic [1:0]       hiloSel,
    output logic             illegal,
    output logic             stall,
    output logic             mdBusy,
    output logic             mdDone,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

    md_state_t state, state_nxt;

    logic               is_r, md_req, hilo_use, accept, start;
    logic [3:0]         alu_nxt;
    logic [1:0]         sel_nxt;
    logic               ill_nxt;

    logic               op_div, neg_q, neg_r, dz;
    logic [WIDTH-1:0]   opd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     add_sum, rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic [2*WIDTH-1:0] acc_step, prod_fix;
    logic [WIDTH-1:0]   q_raw, r_raw, hi_fix, lo_fix;

    // Only instructions that touch HI/LO wait on the engine.
    assign is_r     = (ALUOp == 2'b10);
    assign md_req   = is_r && ((funct == F_MULT) || (funct == F_DIV));
    assign hilo_use = md_req || (is_r && ((funct == F_MFHI) || (funct == F_MFLO)));
    assign mdBusy   = (state != IDLE);
    assign stall    = valid && hilo_use && mdBusy;
    assign accept   = valid && !stall;
    assign start    = accept && md_req;

    always_comb begin
        alu_nxt = 4'b0010;
        sel_nxt = 2'b00;
        ill_nxt = 1'b0;
        case (ALUOp)
            2'b01: alu_nxt = 4'b0110;
            2'b10: begin
                case (funct)
                    F_AND:               alu_nxt = 4'b0000;
                    F_OR:                alu_nxt = 4'b0001;
                    F_ADD, F_MULT, F_DIV: alu_nxt = 4'b0010;
                    F_SUB:               alu_nxt = 4'b0110;
                    F_SLT:               alu_nxt = 4'b0111;
                    F_NOR:               alu_nxt = 4'b1100;
                    F_MFHI:              sel_nxt = 2'b01;
                    F_MFLO:              sel_nxt = 2'b10;
                    default: begin
                        alu_nxt = 4'b1111;
                        ill_nxt = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ALUInput <= 4'b0000;
            hiloSel  <= 2'b00;
            illegal  <= 1'b0;
        end else if (accept) begin
            ALUInput <= alu_nxt;
            hiloSel  <= sel_nxt;
            illegal  <= ill_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Engine works on magnitudes; signs are reapplied in FIX.
    assign a_abs = srcA[WIDTH-1] ? (~srcA + WIDTH'(1)) : srcA;
    assign b_abs = srcB[WIDTH-1] ? (~srcB + WIDTH'(1)) : srcB;

    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, opd} & {(WIDTH+1){acc[0]}});
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff = rem_sh[WIDTH-1:0] - opd;
        if (op_div) begin
            if (rem_sh >= {1'b0, opd}) acc_step = {rem_diff, acc[WIDTH-2:0], 1'b1};
            else                       acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {add_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        q_raw    = acc[WIDTH-1:0];
        r_raw    = acc[2*WIDTH-1:WIDTH];
        prod_fix = neg_q ? (~acc + (2*WIDTH)'(1)) : acc;
        if (op_div) begin
            // Divide by zero leaves |dividend| in the remainder, so the sign fix restores srcA.
            lo_fix = dz ? {WIDTH{1'b1}} : (neg_q ? (~q_raw + WIDTH'(1)) : q_raw);
            hi_fix = neg_r ? (~r_raw + WIDTH'(1)) : r_raw;
        end else begin
            lo_fix = prod_fix[WIDTH-1:0];
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            opd    <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mdDone <= 1'b0;
        end else begin
            mdDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div <= (funct == F_DIV);
                        neg_q  <= srcA[WIDTH-1] ^ srcB[WIDTH-1];
                        neg_r  <= srcA[WIDTH-1];
                        dz     <= (funct == F_DIV) && (srcB == '0);
                        cnt    <= '0;
                        if (funct == F_DIV) begin
                            opd <= b_abs;
                            acc <= {{WIDTH{1'b0}}, a_abs};
                        end else begin
                            opd <= a_abs;
                            acc <= {{WIDTH{1'b0}}, b_abs};
                        end
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    hi     <= hi_fix;
                    lo     <= lo_fix;
                    mdDone <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_md.sv
// Randomised self-checking bench for alu_control_md against a plain-arithmetic
// model of the decode table and signed mult/div.
module tb_alu_control_md;

    localparam int unsigned WIDTH = 32;

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic [31:0] srcA, srcB;
    logic [3:0]  ALUInput;
    logic [1:0]  hiloSel;
    logic        illegal, stall, mdBusy, mdDone;
    logic [31:0] hi, lo;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [3:0] e_alu;
    logic [1:0] e_sel;
    logic       e_ill;

    alu_control_md #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .valid(valid), .ALUOp(ALUOp), .funct(funct),
        .srcA(srcA), .srcB(srcB), .ALUInput(ALUInput), .hiloSel(hiloSel),
        .illegal(illegal), .stall(stall), .mdBusy(mdBusy), .mdDone(mdDone),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void decode_ref(input logic [1:0] op, input logic [5:0] f,
                                       output logic [3:0] alu, output logic [1:0] sel,
                                       output logic ill);
        alu = 4'b0010;
        sel = 2'b00;
        ill = 1'b0;
        if (op == 2'b01) alu = 4'b0110;
        else if (op == 2'b10) begin
            case (f)
                F_AND:  alu = 4'b0000;
                F_OR:   alu = 4'b0001;
                F_ADD, F_MULT, F_DIV: alu = 4'b0010;
                F_SUB:  alu = 4'b0110;
                F_SLT:  alu = 4'b0111;
                F_NOR:  alu = 4'b1100;
                F_MFHI: sel = 2'b01;
                F_MFLO: sel = 2'b10;
                default: begin
                    alu = 4'b1111;
                    ill = 1'b1;
                end
            endcase
        end
    endfunction

    function automatic void md_ref(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
        logic signed [63:0] sa, sb, p, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (!is_div) begin
            p  = sa * sb;
            rh = p[63:32];
            rl = p[31:0];
        end else if (b == 32'd0) begin
            rh = a;
            rl = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            rh = 32'd0;
            rl = 32'h8000_0000;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            rl = q[31:0];
            rh = r[31:0];
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1; valid = 1'b0; ALUOp = 2'b00; funct = 6'd0; srcA = '0; srcB = '0;
        tick();
        tick();
        n_total++; if (ALUInput !== 4'b0000) $display("FAIL reset_alu: got %b want 0000", ALUInput); else n_pass++;
        n_total++; if (hiloSel !== 2'b00) $display("FAIL reset_sel: got %b want 00", hiloSel); else n_pass++;
        n_total++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal); else n_pass++;
        n_total++; if ({mdBusy, mdDone, stall} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {mdBusy, mdDone, stall}); else n_pass++;
        n_total++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h want 0", {hi, lo}); else n_pass++;
        reset = 1'b0;
        e_alu = 4'b0000; e_sel = 2'b00; e_ill = 1'b0;
    endtask

    task automatic test_decode();
        logic [5:0] flist [9] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_NOR, F_MFHI, F_MFLO, 6'b000001};
        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 9; k++) begin
                valid = 1'b1; ALUOp = 2'(op); funct = flist[k];
                #1;
                n_total++; if (stall !== 1'b0) $display("FAIL dec_stall op=%0d f=%b: got %b want 0", op, funct, stall); else n_pass++;
                tick();
                decode_ref(2'(op), flist[k], e_alu, e_sel, e_ill);
                n_total++; if ({ALUInput, hiloSel, illegal} !== {e_alu, e_sel, e_ill})
                    $display("FAIL dec_sweep op=%0d f=%b: got %b/%b/%b want %b/%b/%b", op, flist[k], ALUInput, hiloSel, illegal, e_alu, e_sel, e_ill);
                else n_pass++;
            end
        end
        for (int i = 0; i < 200; i++) begin
            logic v;
            logic [5:0] f;
            logic [1:0] op;
            v  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            if (op == 2'b10 && (f == F_MULT || f == F_DIV)) f = F_MFLO;
            valid = v; ALUOp = op; funct = f;
            tick();
            if (v) decode_ref(op, f, e_alu, e_sel, e_ill);
            n_total++; if ({ALUInput, hiloSel, illegal} !== {e_alu, e_sel, e_ill})
                $display("FAIL dec_rand v=%b op=%b f=%b: got %b/%b/%b want %b/%b/%b", v, op, f, ALUInput, hiloSel, illegal, e_alu, e_sel, e_ill);
            else n_pass++;
        end
        valid = 1'b0;
        tick();
    endtask

    task automatic run_md(input string tag, input logic is_div, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int n, busy;
        md_ref(is_div, a, b, eh, el);
        valid = 1'b1; ALUOp = 2'b10; funct = is_div ? F_DIV : F_MULT; srcA = a; srcB = b;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL %s_issue_stall: got %b want 0", tag, stall); else n_pass++;
        tick();
        valid = 1'b0; srcA = $urandom; srcB = $urandom;
        n_total++; if ({ALUInput, hiloSel, illegal} !== {4'b0010, 2'b00, 1'b0})
            $display("FAIL %s_decode: got %b/%b/%b want 0010/00/0", tag, ALUInput, hiloSel, illegal);
        else n_pass++;
        e_alu = 4'b0010; e_sel = 2'b00; e_ill = 1'b0;
        n = 0; busy = 0;
        while (mdDone !== 1'b1 && n < 100) begin
            if (mdBusy === 1'b1) busy++;
            tick();
            n++;
        end
        n_total++; if (n != WIDTH + 1) $display("FAIL %s_latency: got %0d want %0d", tag, n, WIDTH + 1); else n_pass++;
        n_total++; if (busy != WIDTH + 1) $display("FAIL %s_busy_cycles: got %0d want %0d", tag, busy, WIDTH + 1); else n_pass++;
        n_total++; if (mdBusy !== 1'b0) $display("FAIL %s_busy_end: got %b want 0", tag, mdBusy); else n_pass++;
        n_total++; if ({hi, lo} !== {eh, el}) $display("FAIL %s_result: got %h_%h want %h_%h", tag, hi, lo, eh, el); else n_pass++;
        tick();
        n_total++; if (mdDone !== 1'b0) $display("FAIL %s_done_pulse: got %b want 0", tag, mdDone); else n_pass++;
    endtask

    task automatic test_mult();
        run_md("mult_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        run_md("mult_minmin", 1'b0, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 4; i++) run_md("mult_rand", 1'b0, $urandom, $urandom);
    endtask

    task automatic test_div();
        run_md("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_md("div_5/0", 1'b1, 32'd5, 32'd0);
        run_md("div_neg/0", 1'b1, 32'hFFFF_FF00, 32'd0);
        run_md("div_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] b;
            b = 32'($urandom_range(1, 50));
            if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
            if (i >= 2) b = $urandom;
            run_md("div_rand", 1'b1, $urandom, b);
        end
    endtask

    task automatic test_stall_mflo();
        logic [31:0] eh, el;
        int n;
        md_ref(1'b0, 32'd12345, 32'hFFFF_FD5A, eh, el);
        valid = 1'b1; ALUOp = 2'b10; funct = F_MULT; srcA = 32'd12345; srcB = 32'hFFFF_FD5A;
        tick();
        funct = F_MFLO; srcA = $urandom; srcB = $urandom;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_total++; if (n != WIDTH + 1) $display("FAIL mflo_stall_len: got %0d want %0d", n, WIDTH + 1); else n_pass++;
        n_total++; if (mdDone !== 1'b1) $display("FAIL mflo_release_in_done: got %b want 1", mdDone); else n_pass++;
        n_total++; if ({hi, lo} !== {eh, el}) $display("FAIL mflo_result: got %h_%h want %h_%h", hi, lo, eh, el); else n_pass++;
        n_total++; if (hiloSel !== 2'b00) $display("FAIL mflo_held_while_stalled: got %b want 00", hiloSel); else n_pass++;
        tick();
        valid = 1'b0;
        n_total++; if ({ALUInput, hiloSel, illegal} !== {4'b0010, 2'b10, 1'b0})
            $display("FAIL mflo_accept: got %b/%b/%b want 0010/10/0", ALUInput, hiloSel, illegal);
        else n_pass++;
        n_total++; if (mdBusy !== 1'b0) $display("FAIL mflo_no_start: got %b want 0", mdBusy); else n_pass++;

        md_ref(1'b0, 32'hFFFF_0001, 32'd999, eh, el);
        valid = 1'b1; ALUOp = 2'b10; funct = F_MULT; srcA = 32'hFFFF_0001; srcB = 32'd999;
        tick();
        funct = F_SUB; srcA = $urandom; srcB = $urandom;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL sub_busy_stall: got %b want 0", stall); else n_pass++;
        tick();
        n_total++; if ({ALUInput, hiloSel, illegal} !== {4'b0110, 2'b00, 1'b0})
            $display("FAIL sub_busy_decode: got %b/%b/%b want 0110/00/0", ALUInput, hiloSel, illegal);
        else n_pass++;
        funct = F_MFHI;
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL mfhi_busy_stall: got %b want 1", stall); else n_pass++;
        valid = 1'b0;
        n = 0;
        while (mdDone !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_total++; if ({hi, lo} !== {eh, el}) $display("FAIL sub_busy_result: got %h_%h want %h_%h", hi, lo, eh, el); else n_pass++;
        tick();
        e_alu = 4'b0110; e_sel = 2'b00; e_ill = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] eh1, el1, eh2, el2;
        int n;
        md_ref(1'b0, 32'h0001_2345, 32'h0000_6789, eh1, el1);
        md_ref(1'b0, 32'hFFFF_FFFB, 32'd3, eh2, el2);
        valid = 1'b1; ALUOp = 2'b10; funct = F_MULT; srcA = 32'h0001_2345; srcB = 32'h0000_6789;
        tick();
        srcA = 32'hFFFF_FFFB; srcB = 32'd3;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_total++; if (n != WIDTH + 1) $display("FAIL b2b_stall_len: got %0d want %0d", n, WIDTH + 1); else n_pass++;
        n_total++; if ({hi, lo} !== {eh1, el1}) $display("FAIL b2b_first: got %h_%h want %h_%h", hi, lo, eh1, el1); else n_pass++;
        tick();
        valid = 1'b0; srcA = $urandom; srcB = $urandom;
        n = 0;
        while (mdDone !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_total++; if (n != WIDTH + 1) $display("FAIL b2b_second_latency: got %0d want %0d", n, WIDTH + 1); else n_pass++;
        n_total++; if ({hi, lo} !== {eh2, el2}) $display("FAIL b2b_second: got %h_%h want %h_%h", hi, lo, eh2, el2); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        valid = 1'b1; ALUOp = 2'b10; funct = F_DIV; srcA = 32'hFFF0_BDC0; srcB = 32'd37;
        tick();
        valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++; if ({hi, lo} !== 64'd0) $display("FAIL rst_mid_hilo: got %h_%h want 0_0", hi, lo); else n_pass++;
        n_total++; if (mdBusy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", mdBusy); else n_pass++;
        n_total++; if (mdDone !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", mdDone); else n_pass++;
        n_total++; if (ALUInput !== 4'b0000) $display("FAIL rst_mid_alu: got %b want 0000", ALUInput); else n_pass++;
        e_alu = 4'b0000; e_sel = 2'b00; e_ill = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (mdDone === 1'b1) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL rst_mid_no_done: got %0d pulses want 0", seen); else n_pass++;
        run_md("div_after_rst", 1'b1, 32'hFFF0_BDC0, 32'd37);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mult();
        test_div();
        test_stall_mflo();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
Registered ALU-control decoder with an integrated iterative multiply/divide engine and HI/LO registers. Decodes ALUOp/funct into the 4-bit ALU operation and a result-source select, one cycle after issue. Runs signed mult/div over multiple cycles and raises a stall to the pipeline while HI/LO are not yet valid. Sits between the main control unit and the EX stage of the MIPS datapath.

Parameters:
WIDTH, 32, operand and HI/LO width; mult/div iterate one bit per cycle (WIDTH iterations).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
valid  input  1  an instruction is presented for decode this cycle
ALUOp  input  2  from main control: 00 load/store, 01 beq, 10 R-type, 11 addi
funct  input  6  instruction funct field
srcA  input  WIDTH  rs operand (mult multiplicand / div dividend)
srcB  input  WIDTH  rt operand (mult multiplier / div divisor)
ALUInput  output  4  registered ALU operation code
hiloSel  output  2  registered result select: 00 ALU, 01 HI, 10 LO
illegal  output  1  registered: unrecognised funct under ALUOp=10
stall  output  1  combinational: instruction held, not accepted
mdBusy  output  1  engine not IDLE
mdDone  output  1  one-cycle pulse when HI/LO are written
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: ALUInput=0000, hiloSel=00, illegal=0, mdDone=0, hi=0, lo=0, engine to IDLE. A reset mid-operation aborts it; no mdDone pulse.
- Decode (applied when valid && !stall, on the edge): ALUOp 00 -> 0010; 01 -> 0110; 11 -> 0010; 10 by funct: 100100 and -> 0000; 100101 or -> 0001; 100000 add -> 0010; 100010 sub -> 0110; 101010 slt -> 0111; 100111 nor -> 1100; 011000 mult, 011010 div -> 0010 with the engine started; 010000 mfhi -> 0010, hiloSel=01; 010010 mflo -> 0010, hiloSel=10. Any other funct -> 1111, illegal=1. All other accepted cases clear illegal and set hiloSel=00, except mfhi/mflo.
- valid=0 or stall=1: ALUInput, hiloSel and illegal hold.
- stall = valid && ALUOp==10 && funct in {mult, div, mfhi, mflo} && mdBusy. Other instructions never stall.
- Engine FSM:
  - IDLE -> RUN on an accepted mult/div. That edge latches |srcA|, |srcB|, result signs and the op, and clears the iteration counter.
  - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle. After WIDTH steps -> FIX.
  - FIX: applies sign correction, writes hi/lo, pulses mdDone for the following cycle, -> IDLE.
  - Total: hi/lo updated on the edge WIDTH+1 cycles after the accepting edge (WIDTH=32: 33 cycles). mdBusy is high from the cycle after acceptance through FIX.
- mult: signed; {hi,lo} = 2*WIDTH-bit product.
- div: signed, quotient truncates toward zero; lo = quotient, hi = remainder with the dividend's sign.
  - Divide by zero: hi = srcA, lo = all ones. No exception; still takes the full latency.
  - Most negative / -1: lo = most negative, hi = 0.
- mfhi/mflo accepted in the same cycle mdDone is high see the new values: the stall is already released because mdBusy=0.
- hi/lo change only in FIX or on reset.

Test Plan:
- Decode sweep: valid=1 with each ALUOp and each listed funct -> ALUInput/hiloSel match the table one cycle later. ALUOp=10, funct=000001 -> ALUInput=1111, illegal=1. valid=0 -> outputs hold.
- mult 7 x -3 (WIDTH=32) -> after 33 cycles hi=FFFFFFFF, lo=FFFFFFEB, single mdDone pulse. mdBusy high for exactly the run.
- div -7 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF. div 5 / 0 -> hi=00000005, lo=FFFFFFFF. div 80000000 / FFFFFFFF -> lo=80000000, hi=0.
- mflo issued one cycle after a mult -> stall=1 until mdDone. Accepted in the mdDone cycle with hiloSel=10. An add issued during the busy window -> stall=0, decoded normally.
- Back-to-back: a second mult presented while busy -> stalled, then accepted in the mdDone cycle. Its result is correct and arrives 33 cycles later.
- reset asserted at cycle 10 of a div -> next cycle hi=lo=0, mdBusy=0, no mdDone. A new div afterwards completes correctly.
